irq_ctrl: RTL and testbench

Memory-mapped interrupt aggregator that sits directly downstream of the timer and other peripherals. It captures their event outputs, such as the timer's 1-cycle timeout pulse, into per-source pending bits, and masks them with an enable register. It presents a single registered irq line plus the encoded ID of the highest-priority active source to the CPU. It uses the same sel/we/addr/wdata/rdata peripheral bus as the other IP blocks.

---
 rtl/irq_ctrl.sv | 139 +++++++++++++
 tb/tb_irq_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt aggregator with edge/level capture and priority ID output
//
// Collects per-source events into pending bits, masks them with ENABLE and
// presents a registered irq line plus the ID (index+1) of the lowest-numbered
// active source.
//
// Ports:
//   clk, resetn     - system clock, asynchronous active-low reset
//   sel, we         - bus select and write enable (write when sel && we)
//   addr, wdata     - byte address (addr[4:0] decoded), write data
//   rdata           - combinational read data
//   src[NSRC-1:0]   - event inputs, synchronous to clk
//   irq, irq_id     - registered request and winning source ID (0 = none)

module irq_ctrl #(
    parameter int NSRC = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            sel,
    input  logic            we,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic [NSRC-1:0] src,
    output logic            irq,
    output logic [4:0]      irq_id
);

    localparam logic [4:0] OFF_ENABLE   = 5'h00;
    localparam logic [4:0] OFF_MODE     = 5'h04;
    localparam logic [4:0] OFF_PENDING  = 5'h08;
    localparam logic [4:0] OFF_COMPLETE = 5'h0C;
    localparam logic [4:0] OFF_OVERRUN  = 5'h10;

    logic [NSRC-1:0] enable_q,  enable_d;
    logic [NSRC-1:0] mode_q,    mode_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] overrun_q, overrun_d;
    logic [NSRC-1:0] src_q,     src_d;
    logic            irq_q,     irq_d;
    logic [4:0]      irq_id_q,  irq_id_d;

    logic            wr_en;
    logic [4:0]      off;
    logic [NSRC-1:0] set;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] ovr_clr;
    logic [NSRC-1:0] active;

    logic unused_addr;
    assign unused_addr = ^addr[31:5];

    always_comb begin
        wr_en = sel && we;
        off   = addr[4:0];

        // Level sources set every cycle they are high; edge sources only on a
        // low-to-high transition seen against the previous sample.
        set = src & (mode_q | ~src_q);

        clr = '0;
        if (wr_en && off == OFF_PENDING) begin
            clr = wdata[NSRC-1:0];
        end
        // COMPLETE only matches a clean 1..NSRC value; upper bits must be zero.
        if (wr_en && off == OFF_COMPLETE && wdata[31:5] == 27'd0) begin
            for (int i = 0; i < NSRC; i++) begin
                if (wdata[4:0] == 5'(i + 1)) begin
                    clr[i] = 1'b1;
                end
            end
        end

        ovr_clr = '0;
        if (wr_en && off == OFF_OVERRUN) begin
            ovr_clr = wdata[NSRC-1:0];
        end

        enable_d = enable_q;
        if (wr_en && off == OFF_ENABLE) begin
            enable_d = wdata[NSRC-1:0];
        end
        mode_d = mode_q;
        if (wr_en && off == OFF_MODE) begin
            mode_d = wdata[NSRC-1:0];
        end

        // A new set always wins over a same-cycle clear, for both arrays.
        pending_d = set | (pending_q & ~clr);
        overrun_d = (overrun_q & ~ovr_clr) | (set & ~mode_q & pending_q & ~clr);
        src_d     = src;

        active = pending_q & enable_q;
        irq_d  = |active;
        // Scan downward so the lowest index (highest priority) is left standing.
        irq_id_d = 5'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                irq_id_d = 5'(i + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            enable_q  <= '0;
            mode_q    <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            src_q     <= '0;
            irq_q     <= 1'b0;
            irq_id_q  <= 5'd0;
        end else begin
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            src_q     <= src_d;
            irq_q     <= irq_d;
            irq_id_q  <= irq_id_d;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (addr[4:0])
            OFF_ENABLE:  rdata[NSRC-1:0] = enable_q;
            OFF_MODE:    rdata[NSRC-1:0] = mode_q;
            OFF_PENDING: rdata[NSRC-1:0] = pending_q;
            OFF_OVERRUN: rdata[NSRC-1:0] = overrun_q;
            default:     rdata = 32'd0;
        endcase
    end

    assign irq    = irq_q;
    assign irq_id = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl with a behavioural model

module tb_irq_ctrl;

    localparam int NSRC = 4;

    logic            clk    = 1'b0;
    logic            resetn = 1'b0;
    logic            sel    = 1'b0;
    logic            we     = 1'b0;
    logic [31:0]     addr   = 32'd0;
    logic [31:0]     wdata  = 32'd0;
    logic [31:0]     rdata;
    logic [NSRC-1:0] src    = '0;
    logic            irq;
    logic [4:0]      irq_id;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    bit m_en[NSRC];
    bit m_mode[NSRC];
    bit m_pend[NSRC];
    bit m_ovr[NSRC];
    bit m_prev[NSRC];
    bit m_irq;
    int m_id;

    irq_ctrl #(.NSRC(NSRC)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sel    (sel),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .src    (src),
        .irq    (irq),
        .irq_id (irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSRC; i++) begin
            m_en[i] = 0; m_mode[i] = 0; m_pend[i] = 0; m_ovr[i] = 0; m_prev[i] = 0;
        end
        m_irq = 0;
        m_id  = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        int o;
        r = 32'd0;
        o = int'(a % 32);
        for (int i = 0; i < NSRC; i++) begin
            if (o == 0)  r[i] = m_en[i];
            if (o == 4)  r[i] = m_mode[i];
            if (o == 8)  r[i] = m_pend[i];
            if (o == 16) r[i] = m_ovr[i];
        end
        return r;
    endfunction

    task automatic model_step();
        bit w;
        int o;
        bit s, st, cl, nov;
        w = sel && we;
        o = int'(addr % 32);
        // Outputs reflect the pending/enable state as it stood before this edge.
        m_irq = 0;
        m_id  = 0;
        for (int i = 0; i < NSRC; i++) begin
            if (m_pend[i] && m_en[i]) begin
                m_irq = 1;
                m_id  = i + 1;
                break;
            end
        end
        for (int i = 0; i < NSRC; i++) begin
            s   = src[i];
            st  = m_mode[i] ? s : (s && !m_prev[i]);
            cl  = (w && o == 8 && wdata[i]) || (w && o == 12 && wdata == 32'(i + 1));
            nov = m_ovr[i] && !(w && o == 16 && wdata[i]);
            if (!m_mode[i] && st && m_pend[i] && !cl) nov = 1;
            if (st)      m_pend[i] = 1;
            else if (cl) m_pend[i] = 0;
            m_ovr[i]  = nov;
            m_prev[i] = s;
            if (w && o == 0) m_en[i]   = wdata[i];
            if (w && o == 4) m_mode[i] = wdata[i];
        end
    endtask

    initial model_reset();

    always @(posedge clk or negedge resetn) begin
        if (!resetn) model_reset();
        else         model_step();
    end

    always @(negedge clk) begin
        if (chk_en && resetn === 1'b1) begin
            chk("irq",    {31'd0, irq},     {31'd0, m_irq});
            chk("irq_id", {27'd0, irq_id},  32'(m_id));
            chk("rdata",  rdata,            model_read(addr));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        sel = 1; we = 1; addr = a; wdata = d;
        cyc();
        sel = 0; we = 0;
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
        sel = 1; we = 0; addr = a;
        #1;
        chk(nm, rdata, exp);
    endtask

    initial begin
        repeat (3) cyc();
        resetn = 1;
        chk_en = 1;
        rd_chk("reset_enable",  32'h00, 32'h0);
        rd_chk("reset_pending", 32'h08, 32'h0);
        chk("reset_irq", {27'd0, irq_id} | {31'd0, irq}, 32'd0);
        cyc();

        // Single pulse: pending after the edge, irq one edge later, COMPLETE clears.
        bus_wr(32'h00, 32'h1);
        src = 4'h1; cyc(); src = 4'h0;
        rd_chk("t1_pending", 32'h08, 32'h1);
        chk("t1_irq_lat", {31'd0, irq}, 32'd0);
        cyc();
        chk("t1_irq", {31'd0, irq}, 32'd1);
        chk("t1_id",  {27'd0, irq_id}, 32'd1);
        bus_wr(32'h0C, 32'd1);
        cyc();
        chk("t1_irq_clr", {31'd0, irq}, 32'd0);
        chk("t1_id_clr",  {27'd0, irq_id}, 32'd0);

        // Held-high edge source captures once; level source cannot be cleared while high.
        bus_wr(32'h00, 32'h4);
        src = 4'h4;
        repeat (10) cyc();
        rd_chk("t2_pending", 32'h08, 32'h4);
        rd_chk("t2_overrun", 32'h10, 32'h0);
        bus_wr(32'h08, 32'h4);
        cyc();
        rd_chk("t2_w1c_edge", 32'h08, 32'h0);
        src = 4'h0; cyc();
        bus_wr(32'h04, 32'h4);
        src = 4'h4; cyc(); cyc();
        bus_wr(32'h08, 32'h4);
        rd_chk("t2_level_held", 32'h08, 32'h4);
        src = 4'h0; cyc();
        bus_wr(32'h08, 32'h4);
        rd_chk("t2_level_clr", 32'h08, 32'h0);
        bus_wr(32'h04, 32'h0);
        cyc();

        // Priority: source 1 beats source 3; completing it exposes source 3.
        bus_wr(32'h00, 32'hF);
        src = 4'h8; cyc();
        src = 4'h2; cyc();
        src = 4'h0; cyc(); cyc();
        chk("t3_id2", {27'd0, irq_id}, 32'd2);
        bus_wr(32'h0C, 32'd2);
        cyc();
        chk("t3_irq", {31'd0, irq}, 32'd1);
        chk("t3_id4", {27'd0, irq_id}, 32'd4);
        bus_wr(32'h08, 32'hF);
        cyc();

        // Overrun on repeated edge; W1C loses against a same-cycle new event.
        bus_wr(32'h00, 32'h1);
        src = 4'h1; cyc(); src = 4'h0; cyc();
        src = 4'h1; cyc(); src = 4'h0; cyc();
        rd_chk("t4_overrun", 32'h10, 32'h1);
        cyc();
        src = 4'h1;
        bus_wr(32'h10, 32'h1);
        src = 4'h0;
        rd_chk("t4_ovr_setwins", 32'h10, 32'h1);
        bus_wr(32'h10, 32'h1);
        rd_chk("t4_ovr_w1c", 32'h10, 32'h0);
        bus_wr(32'h08, 32'hF);
        cyc();

        // Late enable raises irq for an already-pending event; async reset drops all.
        bus_wr(32'h00, 32'h0);
        src = 4'h1; cyc(); src = 4'h0; cyc();
        src = 4'h1; cyc(); src = 4'h0; cyc();
        chk("t5_irq_masked", {31'd0, irq}, 32'd0);
        bus_wr(32'h00, 32'h1);
        chk("t5_irq_notyet", {31'd0, irq}, 32'd0);
        cyc();
        chk("t5_irq_en", {31'd0, irq}, 32'd1);
        rd_chk("t5_ovr_pre", 32'h10, 32'h1);
        resetn = 0;
        sel = 0;
        #1;
        chk("t5_rst_irq", {31'd0, irq}, 32'd0);
        chk("t5_rst_id",  {27'd0, irq_id}, 32'd0);
        addr = 32'h08; #1;
        chk("t5_rst_pend", rdata, 32'd0);
        addr = 32'h10; #1;
        chk("t5_rst_ovr", rdata, 32'd0);
        cyc(); cyc();
        resetn = 1;
        cyc();

        // Illegal COMPLETE values and unmapped offsets leave state untouched.
        bus_wr(32'h00, 32'h3);
        src = 4'h2; cyc(); src = 4'h0; cyc();
        bus_wr(32'h0C, 32'd0);
        bus_wr(32'h0C, 32'd7);
        bus_wr(32'h0C, 32'h22);
        bus_wr(32'h14, 32'hFFFF_FFFF);
        rd_chk("t6_pending", 32'h08, 32'h2);
        rd_chk("t6_enable",  32'h00, 32'h3);
        cyc();
        rd_chk("t6_rd_0c", 32'h0C, 32'h0);
        rd_chk("t6_rd_14", 32'h14, 32'h0);
        cyc();
        chk("t6_id", {27'd0, irq_id}, 32'd2);
        bus_wr(32'h0C, 32'd2);
        rd_chk("t6_complete", 32'h08, 32'h0);
        cyc();

        // Randomized traffic against the model, with one mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (c == 1500) resetn = 0;
            if (c == 1503) resetn = 1;
            if ($urandom_range(0, 2) == 0) src = 4'($urandom);
            sel = ($urandom_range(0, 2) == 0);
            we  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 7))
                0: addr = 32'h00;
                1: addr = 32'h04;
                2: addr = 32'h08;
                3: addr = 32'h0C;
                4: addr = 32'h10;
                5: addr = 32'h14;
                6: addr = $urandom;
                default: addr = {$urandom_range(0, 255), 5'h0C} | 32'h0;
            endcase
            if ($urandom_range(0, 1) == 0) wdata = 32'($urandom_range(0, 6));
            else                           wdata = $urandom;
        end
        sel = 0; we = 0;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
